// File: rtl/ahbl_gpio_if.sv
// AHB-Lite slave-side bus bundle for the GPIO block.
// Carries the address/data-phase signals between a bus master (or decoder
// fabric) and the GPIO slave. Clock and reset are kept outside the bundle.
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY : master -> slave
//   HREADYOUT, HRDATA                                   : slave  -> master
interface ahbl_gpio_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/ahbl_gpio.sv
// AHB-Lite GPIO peripheral, zero wait states.
// Registers (word offsets from HADDR[7:2]):
//   0x00 DATAI (RO)  synchronised pad inputs
//   0x04 DATAO (RW)  pad output values
//   0x08 DIR   (RW)  pad output enables (1 = drive)
//   0x0C IM    (RW)  interrupt mask
//   0x10 IS    (RO, write-1-to-clear) edge status
//   0x14 POL   (RW)  edge polarity per bit (1 = rising, 0 = falling)
// Ports:
//   HCLK, HRESET : clock, asynchronous active-high reset
//   bus          : AHB-Lite slave bundle (ahbl_gpio_if.slave)
//   GPIO_IN      : pad inputs, asynchronous to HCLK
//   GPIO_OUT     : pad outputs (DATAO)
//   GPIO_OE      : pad output enables (DIR)
//   IRQ          : registered level interrupt, |(IS & IM)
module ahbl_gpio #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    ahbl_gpio_if.slave       bus,
    input  logic [WIDTH-1:0] GPIO_IN,
    output logic [WIDTH-1:0] GPIO_OUT,
    output logic [WIDTH-1:0] GPIO_OE,
    output logic             IRQ
);

    typedef enum logic [5:0] {
        OFF_DATAI = 6'h00,
        OFF_DATAO = 6'h01,
        OFF_DIR   = 6'h02,
        OFF_IM    = 6'h03,
        OFF_IS    = 6'h04,
        OFF_POL   = 6'h05
    } reg_off_e;

    localparam logic [31:0] UNMAPPED_VALUE = 32'hBADDBEEF;

    // Bus data-phase state
    logic [5:0]       addr_q, addr_d;
    logic             wr_q, wr_d;

    // Register file
    logic [WIDTH-1:0] datao_q, datao_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] im_q, im_d;
    logic [WIDTH-1:0] is_q, is_d;
    logic [WIDTH-1:0] pol_q, pol_d;

    // Input synchroniser (s1, s2) plus edge-history stage (s3)
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] s3_q, s3_d;

    logic             irq_q, irq_d;

    logic             accept;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] edge_det;
    logic [31:0]      rdata;

    // HSIZE and the untouched address/data bits are intentionally unused.
    logic             unused_bus_bits;

    assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    // The data phase ends on the first edge with HREADY high.
    assign wr_en  = wr_q & bus.HREADY;
    assign wdata  = bus.HWDATA[WIDTH-1:0];

    // Edge on bit i: s2 just changed (differs from s3) and now matches POL.
    assign edge_det = (s2_q ^ s3_q) & ~(s2_q ^ pol_q);

    assign unused_bus_bits = ^{bus.HSIZE, bus.HADDR[31:8], bus.HADDR[1:0],
                               bus.HWDATA, bus.HTRANS[0]};

    always_comb begin
        addr_d = addr_q;
        wr_d   = wr_q;
        if (accept) begin
            addr_d = bus.HADDR[7:2];
            wr_d   = bus.HWRITE;
        end else if (bus.HREADY) begin
            wr_d   = 1'b0;
        end
    end

    always_comb begin
        datao_d = datao_q;
        dir_d   = dir_q;
        im_d    = im_q;
        pol_d   = pol_q;
        is_d    = is_q;
        if (wr_en) begin
            case (addr_q)
                OFF_DATAO: datao_d = wdata;
                OFF_DIR:   dir_d   = wdata;
                OFF_IM:    im_d    = wdata;
                OFF_IS:    is_d    = is_q & ~wdata;
                OFF_POL:   pol_d   = wdata;
                default:   ;
            endcase
        end
        // Applied after the W1C so a coincident edge keeps the bit set.
        is_d = is_d | edge_det;
    end

    always_comb begin
        s1_d  = GPIO_IN;
        s2_d  = s1_q;
        s3_d  = s2_q;
        irq_d = |(is_q & im_q);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            datao_q <= '0;
            dir_q   <= '0;
            im_q    <= '0;
            is_q    <= '0;
            pol_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            datao_q <= datao_d;
            dir_q   <= dir_d;
            im_q    <= im_d;
            is_q    <= is_d;
            pol_q   <= pol_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            irq_q   <= irq_d;
        end
    end

    // Read mux driven from the registered offset; bits above WIDTH stay 0.
    always_comb begin
        rdata = '0;
        case (addr_q)
            OFF_DATAI: rdata[WIDTH-1:0] = s2_q;
            OFF_DATAO: rdata[WIDTH-1:0] = datao_q;
            OFF_DIR:   rdata[WIDTH-1:0] = dir_q;
            OFF_IM:    rdata[WIDTH-1:0] = im_q;
            OFF_IS:    rdata[WIDTH-1:0] = is_q;
            OFF_POL:   rdata[WIDTH-1:0] = pol_q;
            default:   rdata = UNMAPPED_VALUE;
        endcase
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign GPIO_OUT      = datao_q;
    assign GPIO_OE       = dir_q;
    assign IRQ           = irq_q;

endmodule
